// File: rtl/pulse_stretcher.sv
//==============================================================================
// Module   : pulse_stretcher
// Brief    : Stretches one-cycle strobes into HIGH_CYCLES-high / LOW_CYCLES-low
//            level bursts, queueing strobes that arrive mid-burst.
//            Optional macro: PULSE_STRETCH_RETRIGGER_EN (pulses during HIGH
//            extend the high phase instead of queueing).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module pulse_stretcher #(
    parameter int HIGH_CYCLES = 4,
    parameter int LOW_CYCLES  = 2,
    parameter int PEND_W      = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pulse_in,
    input  logic              clear_ovf,
    output logic              level_out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    localparam int MAX_CYCLES = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
    localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CW-1:0]     HIGH_LOAD = CW'(HIGH_CYCLES - 1);
    localparam logic [CW-1:0]     LOW_LOAD  = CW'(LOW_CYCLES - 1);
    localparam logic [CW-1:0]     CNT_ONE   = CW'(1);
    localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_LOW  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q,   cnt_d;
    logic [PEND_W-1:0] pend_q,  pend_d;
    logic              ovf_q,   ovf_d;
    logic              level_q, level_d;
    logic              busy_q,  busy_d;

    logic w_cnt_zero;
    logic w_pend_nz;
    logic w_pend_max;
    logic w_pend_inc;
    logic w_pend_dec;
    logic w_ovf_set;

    assign w_cnt_zero = (cnt_q == '0);
    assign w_pend_nz  = (pend_q != '0);
    assign w_pend_max = &pend_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        w_pend_inc = 1'b0;
        w_pend_dec = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pulse_in) begin
                    state_d = ST_HIGH;
                    cnt_d   = HIGH_LOAD;
                end
            end

            ST_HIGH: begin
`ifdef PULSE_STRETCH_RETRIGGER_EN
                if (pulse_in) begin
                    cnt_d = HIGH_LOAD;
                end else if (w_cnt_zero) begin
                    state_d = ST_LOW;
                    cnt_d   = LOW_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
`else
                w_pend_inc = pulse_in;
                if (w_cnt_zero) begin
                    state_d = ST_LOW;
                    cnt_d   = LOW_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
`endif
            end

            ST_LOW: begin
                if (w_cnt_zero) begin
                    if (w_pend_nz) begin
                        // Replay the oldest queued pulse; a strobe this cycle joins the queue.
                        state_d    = ST_HIGH;
                        cnt_d      = HIGH_LOAD;
                        w_pend_dec = 1'b1;
                        w_pend_inc = pulse_in;
                    end else if (pulse_in) begin
                        state_d = ST_HIGH;
                        cnt_d   = HIGH_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d      = cnt_q - CNT_ONE;
                    w_pend_inc = pulse_in;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        pend_d    = pend_q;
        w_ovf_set = 1'b0;

        if (w_pend_inc && !w_pend_dec) begin
            if (w_pend_max) begin
                w_ovf_set = 1'b1;
            end else begin
                pend_d = pend_q + PEND_ONE;
            end
        end else if (w_pend_dec && !w_pend_inc) begin
            pend_d = pend_q - PEND_ONE;
        end

        // A loss event in the same cycle as a clear must remain visible.
        if (w_ovf_set) begin
            ovf_d = 1'b1;
        end else if (clear_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end

        level_d = (state_d == ST_HIGH);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            level_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            level_q <= level_d;
            busy_q  <= busy_d;
        end
    end

    assign level_out = level_q;
    assign busy      = busy_q;
    assign pending   = pend_q;
    assign overflow  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_pulse_stretcher.sv
//==============================================================================
// Module   : tb_pulse_stretcher
// Brief    : Directed self-checking bench for pulse_stretcher (4/2/2 config).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_pulse_stretcher;

    localparam int HIGH_CYCLES = 4;
    localparam int LOW_CYCLES  = 2;
    localparam int PEND_W      = 2;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              pulse_in = 1'b0;
    logic              clear_ovf = 1'b0;
    logic              level_out;
    logic              busy;
    logic [PEND_W-1:0] pending;
    logic              overflow;

    int checks = 0;
    int fails  = 0;

    pulse_stretcher #(
        .HIGH_CYCLES (HIGH_CYCLES),
        .LOW_CYCLES  (LOW_CYCLES),
        .PEND_W      (PEND_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .pulse_in  (pulse_in),
        .clear_ovf (clear_ovf),
        .level_out (level_out),
        .busy      (busy),
        .pending   (pending),
        .overflow  (overflow)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++;
        if ({level_out, busy, pending, overflow} !== 5'b0) begin
            fails++;
            $display("FAIL reset_hold got lvl=%b busy=%b pend=%0d ovf=%b want all 0",
                     level_out, busy, pending, overflow);
        end
        reset = 1'b0;
        step();
        checks++;
        if ({level_out, busy, pending, overflow} !== 5'b0) begin
            fails++;
            $display("FAIL reset_release got lvl=%b busy=%b pend=%0d ovf=%b want all 0",
                     level_out, busy, pending, overflow);
        end
    endtask

    task automatic test_single();
        logic e_lvl, e_busy;
        for (int c = 0; c <= 8; c++) begin
            pulse_in = (c == 0);
            e_lvl  = (c >= 1 && c <= 4);
            e_busy = (c >= 1 && c <= 6);
            checks++;
            if (level_out !== e_lvl) begin
                fails++;
                $display("FAIL single_level c=%0d got %b want %b", c, level_out, e_lvl);
            end
            checks++;
            if (busy !== e_busy) begin
                fails++;
                $display("FAIL single_busy c=%0d got %b want %b", c, busy, e_busy);
            end
            checks++;
            if (pending !== 2'd0) begin
                fails++;
                $display("FAIL single_pending c=%0d got %0d want 0", c, pending);
            end
            step();
        end
        pulse_in = 1'b0;
    endtask

    task automatic test_queue();
        logic       e_lvl, e_busy;
        logic [1:0] e_pend;
        for (int c = 0; c <= 20; c++) begin
            pulse_in = (c == 0 || c == 2 || c == 3);
            e_lvl  = (c >= 1 && c <= 4) || (c >= 7 && c <= 10) || (c >= 13 && c <= 16);
            e_busy = (c >= 1 && c <= 18);
            e_pend = (c == 3) ? 2'd1 : (c >= 4 && c <= 6) ? 2'd2 :
                     (c >= 7 && c <= 12) ? 2'd1 : 2'd0;
            checks++;
            if (level_out !== e_lvl) begin
                fails++;
                $display("FAIL queue_level c=%0d got %b want %b", c, level_out, e_lvl);
            end
            checks++;
            if (busy !== e_busy) begin
                fails++;
                $display("FAIL queue_busy c=%0d got %b want %b", c, busy, e_busy);
            end
            checks++;
            if (pending !== e_pend) begin
                fails++;
                $display("FAIL queue_pending c=%0d got %0d want %0d", c, pending, e_pend);
            end
            step();
        end
        pulse_in = 1'b0;
    endtask

    task automatic test_saturate();
        logic       e_lvl, e_busy, e_ovf;
        logic [1:0] e_pend;
        for (int c = 0; c <= 26; c++) begin
            pulse_in  = (c <= 4);
            clear_ovf = (c == 8);
            e_lvl  = (c >= 1 && c <= 4) || (c >= 7 && c <= 10) ||
                     (c >= 13 && c <= 16) || (c >= 19 && c <= 22);
            e_busy = (c >= 1 && c <= 24);
            e_ovf  = (c >= 5 && c <= 8);
            e_pend = (c == 2) ? 2'd1 : (c == 3) ? 2'd2 : (c >= 4 && c <= 6) ? 2'd3 :
                     (c >= 7 && c <= 12) ? 2'd2 : (c >= 13 && c <= 18) ? 2'd1 : 2'd0;
            checks++;
            if (level_out !== e_lvl) begin
                fails++;
                $display("FAIL sat_level c=%0d got %b want %b", c, level_out, e_lvl);
            end
            checks++;
            if (busy !== e_busy) begin
                fails++;
                $display("FAIL sat_busy c=%0d got %b want %b", c, busy, e_busy);
            end
            checks++;
            if (pending !== e_pend) begin
                fails++;
                $display("FAIL sat_pending c=%0d got %0d want %0d", c, pending, e_pend);
            end
            checks++;
            if (overflow !== e_ovf) begin
                fails++;
                $display("FAIL sat_overflow c=%0d got %b want %b", c, overflow, e_ovf);
            end
            step();
        end
        pulse_in  = 1'b0;
        clear_ovf = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic e_lvl, e_busy;
        for (int c = 0; c <= 14; c++) begin
            pulse_in = (c == 0 || c == 6);
            e_lvl  = (c >= 1 && c <= 4) || (c >= 7 && c <= 10);
            e_busy = (c >= 1 && c <= 12);
            checks++;
            if (level_out !== e_lvl) begin
                fails++;
                $display("FAIL b2b_level c=%0d got %b want %b", c, level_out, e_lvl);
            end
            checks++;
            if (busy !== e_busy) begin
                fails++;
                $display("FAIL b2b_busy c=%0d got %b want %b", c, busy, e_busy);
            end
            checks++;
            if (pending !== 2'd0) begin
                fails++;
                $display("FAIL b2b_pending c=%0d got %0d want 0", c, pending);
            end
            step();
        end
        pulse_in = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic       e_lvl, e_busy;
        logic [1:0] e_pend;
        for (int c = 0; c <= 13; c++) begin
            pulse_in = (c <= 2 || c == 6);
            if (c == 5) reset = 1'b0;
            if (c == 3) begin
`ifdef PULSE_STRETCH_RETRIGGER_EN
                e_pend = 2'd0;
`else
                e_pend = 2'd2;
`endif
                checks++;
                if (level_out !== 1'b1 || pending !== e_pend) begin
                    fails++;
                    $display("FAIL rst_mid_pre got lvl=%b pend=%0d want lvl=1 pend=%0d",
                             level_out, pending, e_pend);
                end
                reset = 1'b1;
                #2;
                checks++;
                if ({level_out, busy, pending, overflow} !== 5'b0) begin
                    fails++;
                    $display("FAIL rst_mid_async got lvl=%b busy=%b pend=%0d ovf=%b want all 0",
                             level_out, busy, pending, overflow);
                end
            end else begin
                e_lvl  = (c >= 1 && c <= 2) || (c >= 7 && c <= 10);
                e_busy = (c >= 1 && c <= 2) || (c >= 7 && c <= 12);
`ifdef PULSE_STRETCH_RETRIGGER_EN
                e_pend = 2'd0;
`else
                e_pend = (c == 2) ? 2'd1 : 2'd0;
`endif
                checks++;
                if (level_out !== e_lvl || busy !== e_busy || pending !== e_pend) begin
                    fails++;
                    $display("FAIL rst_mid c=%0d got lvl=%b busy=%b pend=%0d want lvl=%b busy=%b pend=%0d",
                             c, level_out, busy, pending, e_lvl, e_busy, e_pend);
                end
            end
            step();
        end
        pulse_in = 1'b0;
        reset    = 1'b0;
    endtask

`ifdef PULSE_STRETCH_RETRIGGER_EN
    task automatic test_retrigger();
        logic e_lvl, e_busy;
        for (int c = 0; c <= 11; c++) begin
            pulse_in = (c == 0 || c == 3);
            e_lvl  = (c >= 1 && c <= 7);
            e_busy = (c >= 1 && c <= 9);
            checks++;
            if (level_out !== e_lvl || busy !== e_busy || pending !== 2'd0) begin
                fails++;
                $display("FAIL retrig c=%0d got lvl=%b busy=%b pend=%0d want lvl=%b busy=%b pend=0",
                         c, level_out, busy, pending, e_lvl, e_busy);
            end
            step();
        end
        pulse_in = 1'b0;
    endtask
`endif

    initial begin
        #1;
        test_reset();
        test_single();
`ifdef PULSE_STRETCH_RETRIGGER_EN
        test_retrigger();
`else
        test_queue();
        test_saturate();
`endif
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired after %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
